// File: rtl/keypad_time_entry.sv
// Keypad time-entry front end for the microwave countdown chain: collects BCD
// keypresses into an mm:ss buffer, normalizes seconds, and issues a load pulse.
module keypad_time_entry #(
    parameter int MAX_DIGITS = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       commit,
    input  logic       cancel,
    input  logic       timer_running,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [2:0] digit_count,
    output logic       loadn,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {ENTRY, NORM, LOAD} state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    state_t     state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_units_q, min_units_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_units_q, sec_units_d;
    logic [2:0] count_q, count_d;
    logic       loadn_q, loadn_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    always_comb begin
        state_d     = state_q;
        min_tens_d  = min_tens_q;
        min_units_d = min_units_q;
        sec_tens_d  = sec_tens_q;
        sec_units_d = sec_units_q;
        count_d     = count_q;
        err_d       = 1'b0;

        case (state_q)
            ENTRY: begin
                if (cancel) begin
                    min_tens_d  = 4'd0;
                    min_units_d = 4'd0;
                    sec_tens_d  = 4'd0;
                    sec_units_d = 4'd0;
                    count_d     = 3'd0;
                end else if (commit) begin
                    if (count_q != 3'd0 && !timer_running) begin
                        state_d = NORM;
                    end else begin
                        err_d = 1'b1;
                    end
                    // A digit arriving with commit is dropped and flagged.
                    if (digit_valid) begin
                        err_d = 1'b1;
                    end
                end else if (digit_valid) begin
                    if (digit <= 4'd9 && count_q < MAX_CNT && !timer_running) begin
                        min_tens_d  = min_units_q;
                        min_units_d = sec_tens_q;
                        sec_tens_d  = sec_units_q;
                        sec_units_d = digit;
                        count_d     = count_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            NORM: begin
                err_d = digit_valid | commit;
                if (cancel) begin
                    min_tens_d  = 4'd0;
                    min_units_d = 4'd0;
                    sec_tens_d  = 4'd0;
                    sec_units_d = 4'd0;
                    count_d     = 3'd0;
                    err_d       = 1'b0;
                    state_d     = ENTRY;
                end else if (timer_running) begin
                    err_d   = 1'b1;
                    state_d = ENTRY;
                end else begin
                    // Fold 60..99 seconds into one extra minute, saturating at 99:59.
                    if (sec_tens_q >= 4'd6) begin
                        if (min_tens_q == 4'd9 && min_units_q == 4'd9) begin
                            sec_tens_d  = 4'd5;
                            sec_units_d = 4'd9;
                        end else begin
                            sec_tens_d = sec_tens_q - 4'd6;
                            if (min_units_q == 4'd9) begin
                                min_units_d = 4'd0;
                                min_tens_d  = min_tens_q + 4'd1;
                            end else begin
                                min_units_d = min_units_q + 4'd1;
                            end
                        end
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                err_d       = digit_valid | commit;
                min_tens_d  = 4'd0;
                min_units_d = 4'd0;
                sec_tens_d  = 4'd0;
                sec_units_d = 4'd0;
                count_d     = 3'd0;
                state_d     = ENTRY;
            end
            default: begin
                state_d = ENTRY;
            end
        endcase

        loadn_d = (state_d != LOAD);
        busy_d  = (state_d != ENTRY);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= ENTRY;
            min_tens_q  <= 4'd0;
            min_units_q <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_units_q <= 4'd0;
            count_q     <= 3'd0;
            loadn_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_tens_q  <= min_tens_d;
            min_units_q <= min_units_d;
            sec_tens_q  <= sec_tens_d;
            sec_units_q <= sec_units_d;
            count_q     <= count_d;
            loadn_q     <= loadn_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign min_tens    = min_tens_q;
    assign min_units   = min_units_q;
    assign sec_tens    = sec_tens_q;
    assign sec_units   = sec_units_q;
    assign digit_count = count_q;
    assign loadn       = loadn_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Bench for keypad_time_entry: directed literal checks followed by random
// stimulus, all compared every cycle against a decimal-number model of the buffer.
module tb_keypad_time_entry;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       commit = 1'b0;
    logic       cancel = 1'b0;
    logic       timer_running = 1'b0;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic [2:0] digit_count;
    logic       loadn, busy, err;

    int total = 0;
    int bad = 0;

    // Model: buffer as the decimal number mmss, phase 0=entry 1=norm 2=load.
    int m_val = 0;
    int m_cnt = 0;
    int m_ph = 0;
    int m_err = 0;
    bit m_init = 1'b0;

    keypad_time_entry #(.MAX_DIGITS(4)) dut (
        .clock(clock), .clear(clear), .digit_valid(digit_valid), .digit(digit),
        .commit(commit), .cancel(cancel), .timer_running(timer_running),
        .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
        .sec_units(sec_units), .digit_count(digit_count), .loadn(loadn),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (clear) begin
            m_val = 0; m_cnt = 0; m_ph = 0; m_err = 0; m_init = 1'b1;
        end else begin
            case (m_ph)
                0: begin
                    m_err = 0;
                    if (cancel) begin
                        m_val = 0; m_cnt = 0;
                    end else if (commit) begin
                        if (m_cnt > 0 && !timer_running) m_ph = 1;
                        else m_err = 1;
                        if (digit_valid) m_err = 1;
                    end else if (digit_valid) begin
                        if (digit <= 9 && m_cnt < 4 && !timer_running) begin
                            m_val = (m_val * 10 + int'(digit)) % 10000;
                            m_cnt++;
                        end else m_err = 1;
                    end
                end
                1: begin
                    m_err = (digit_valid || commit) ? 1 : 0;
                    if (cancel) begin
                        m_val = 0; m_cnt = 0; m_ph = 0; m_err = 0;
                    end else if (timer_running) begin
                        m_ph = 0; m_err = 1;
                    end else begin
                        if ((m_val % 100) >= 60) begin
                            if (m_val / 100 == 99) m_val = 9959;
                            else m_val = (m_val / 100 + 1) * 100 + (m_val % 100) - 60;
                        end
                        m_ph = 2;
                    end
                end
                default: begin
                    m_err = (digit_valid || commit) ? 1 : 0;
                    m_val = 0; m_cnt = 0; m_ph = 0;
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (m_init) begin
            chk("min_tens", int'(min_tens), m_val / 1000);
            chk("min_units", int'(min_units), (m_val / 100) % 10);
            chk("sec_tens", int'(sec_tens), (m_val / 10) % 10);
            chk("sec_units", int'(sec_units), m_val % 10);
            chk("digit_count", int'(digit_count), m_cnt);
            chk("loadn", int'(loadn), (m_ph == 2) ? 0 : 1);
            chk("busy", int'(busy), (m_ph != 0) ? 1 : 0);
            chk("err", int'(err), m_err);
        end
    end

    task automatic drive(input bit c, input bit dv, input int dg, input bit cm,
                         input bit cn, input bit tr);
        @(negedge clock);
        clear = c; digit_valid = dv; digit = 4'(dg);
        commit = cm; cancel = cn; timer_running = tr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic key(input int dg);
        drive(0, 1, dg, 0, 0, 0);
    endtask

    task automatic chk_buf(input string nm, input int mmss, input int cnt);
        chk(nm, int'(min_tens) * 1000 + int'(min_units) * 100 +
                int'(sec_tens) * 10 + int'(sec_units), mmss);
        chk({nm, "_cnt"}, int'(digit_count), cnt);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        idle();
        chk_buf("reset", 0, 0);
        chk("reset_loadn", int'(loadn), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);

        key(1); key(3); key(0);
        drive(0, 0, 0, 1, 0, 0);
        idle();
        chk_buf("t1_norm", 130, 3);
        chk("t1_norm_busy", int'(busy), 1);
        chk("t1_norm_loadn", int'(loadn), 1);
        idle();
        chk_buf("t1_load", 130, 3);
        chk("t1_load_loadn", int'(loadn), 0);
        idle();
        chk_buf("t1_after", 0, 0);
        chk("t1_after_loadn", int'(loadn), 1);

        key(0); key(0); key(7); key(5);
        drive(0, 0, 0, 1, 0, 0);
        idle();
        idle();
        chk_buf("t2_load", 115, 4);
        chk("t2_load_loadn", int'(loadn), 0);
        idle();

        key(9); key(9); key(9); key(9);
        key(3);
        idle();
        chk_buf("t3_fifth", 9999, 4);
        chk("t3_fifth_err", int'(err), 1);
        drive(0, 0, 0, 1, 0, 0);
        idle();
        idle();
        chk_buf("t3_sat", 9959, 4);
        chk("t3_sat_loadn", int'(loadn), 0);
        idle();

        key(12);
        idle();
        chk("t4_badkey_err", int'(err), 1);
        chk_buf("t4_badkey", 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle();
        chk("t4_empty_commit_err", int'(err), 1);
        chk("t4_empty_commit_busy", int'(busy), 0);
        key(2);
        drive(0, 0, 0, 1, 0, 1);
        idle();
        chk("t4_running_err", int'(err), 1);
        chk("t4_running_busy", int'(busy), 0);
        chk_buf("t4_running", 2, 1);

        drive(0, 0, 0, 0, 1, 0);
        key(2); key(5);
        drive(0, 1, 4, 0, 1, 0);
        idle();
        chk_buf("t5_cancel", 0, 0);
        chk("t5_cancel_err", int'(err), 0);

        key(8);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("t5_norm_busy", int'(busy), 1);
        idle();
        chk("t5_ncancel_loadn", int'(loadn), 1);
        chk("t5_ncancel_busy", int'(busy), 0);
        idle();
        chk("t5_ncancel_loadn2", int'(loadn), 1);

        key(4);
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("t6_norm_busy", int'(busy), 1);
        idle();
        chk_buf("t6_clear", 0, 0);
        chk("t6_clear_loadn", int'(loadn), 1);
        chk("t6_clear_busy", int'(busy), 0);
        idle();
        chk("t6_clear_loadn2", int'(loadn), 1);

        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                               : int'($urandom_range(0, 9)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0));
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
